sensor_conditioner: RTL and testbench
=====================================

# sensor_conditioner

- Input conditioning stage directly upstream of the irrigation controller top.
- Takes the seven raw switch/sensor inputs and produces clean, glitch-free levels for the level/error, irrigation and display logic:
  - level sensors H, M, L
  - soil/air humidity Us, Ua
  - temperature T
  - dry-soil Sd
- Each channel gets a two-flop synchronizer and a counter-based debouncer.
- A global `stable` flag tells downstream logic when every channel has settled since reset.

## Interface
Parameters:
- `N_CH`, 7, number of conditioned channels.
- `DEB_CYCLES`, 50000, consecutive cycles a new synchronized value must persist before acceptance (1 ms at 50 MHz). Must be ≥ 2.
- `CNT_W`, `$clog2(DEB_CYCLES)`, debounce counter width.

Ports:
- `clock` in 1: system clock. All logic is on the rising edge; single clock domain.
- `Rst` in 1: asynchronous, active-high reset.
- `raw_in` in `N_CH`: unsynchronized inputs. Bit order is 0=H, 1=M, 2=L, 3=Us, 4=Ua, 5=T, 6=Sd.
- `clean_out` out `N_CH`: debounced levels, same bit order.
- `stable` out 1: high when the startup window has expired and no channel is mid-debounce.
- `rise_pulse` out `N_CH`: one-cycle pulse when `clean_out[i]` goes 0→1. Present only with `SENSOR_EDGE_EN`.
- `fall_pulse` out `N_CH`: one-cycle pulse when `clean_out[i]` goes 1→0. Present only with `SENSOR_EDGE_EN`.

## Operation
Per channel, fully independent:
- Synchronizer: `s1 <= raw_in[i]`, `s2 <= s1`. Both reset to 0.
- State IDLE (`s2 == clean`):
  - Counter held at 0.
  - Moves to COUNT when `s2 != clean`.
- State COUNT (`s2 != clean`):
  - Counter increments each cycle.
  - If `s2` returns equal to `clean`, the counter clears and the state returns to IDLE. No partial credit is kept.
  - When counter == `DEB_CYCLES-1` and `s2` still differs: `clean <= s2`, counter clears, state returns to IDLE.
- The counter never wraps, because it is cleared at the terminal count.
- Pulses shorter than `DEB_CYCLES` synchronized cycles never reach `clean_out`.

Global `stable`:
- A startup counter runs from reset release for `DEB_CYCLES+2` cycles, then saturates.
- The `stable` register is 1 iff the startup counter has expired and every channel is IDLE.
- It therefore drops while any channel is counting.

Boundary conditions:
- Simultaneous changes on several channels are handled independently. Equal timing gives a same-cycle update.
- Raw toggling every cycle keeps the channel in COUNT/IDLE alternation, and `clean` never changes.
- `Rst` mid-count immediately clears the synchronizers, counters, `clean_out`, `stable`, the startup counter and the pulses.

## Timing
- Reset values: `clean_out`=0, `stable`=0, `rise_pulse`/`fall_pulse`=0.
- Latency from a clean raw step to `clean_out`: 2 synchronizer cycles + `DEB_CYCLES` cycles.
- The edge pulse is asserted in the same cycle `clean_out` updates, for exactly one cycle.
- `stable` lags channel state by one cycle, because it is registered.
- After reset with steady raw inputs:
  - If any input is 1, the corresponding `clean_out` rises `DEB_CYCLES+2` cycles after release. `stable` rises on the cycle after all channels are IDLE.
  - If all inputs are 0, `stable` rises at cycle `DEB_CYCLES+3`.

## Configuration
- Macro `SENSOR_EDGE_EN`.
- Defined: `rise_pulse` and `fall_pulse` ports and their registers exist.
- Undefined: both ports and their logic are omitted; `clean_out` and `stable` behave identically in both builds.

## Structure
- Shared package `sensor_pkg` holds:
  - channel index constants `CH_H`=0, `CH_M`=1, `CH_L`=2, `CH_US`=3, `CH_UA`=4, `CH_T`=5, `CH_SD`=6
  - `N_CH_DEF`
  - `DEB_CYCLES_DEF`
  - channel state enum (IDLE, COUNT)
- One sub-module, `debounce_channel`:
  - Contains the synchronizer, counter, FSM and optional edge detector for one bit.
  - Instantiated `N_CH` times by a generate loop.
- The top holds the startup counter and the `stable` register.

## Test plan
All scenarios use `DEB_CYCLES`=8.
- Reset with `raw_in`=0: all outputs are 0 during `Rst`. `stable`=1 at cycle 11 after release; `clean_out` stays 0.
- `raw_in[CH_H]` steps 0→1 and is held: `clean_out[0]` rises exactly 10 cycles later. With `SENSOR_EDGE_EN`, `rise_pulse[0]` is high for that single cycle. `stable` is low during the count.
- Glitch: `raw_in[CH_L]` high for 7 cycles, then 0: `clean_out[2]` stays 0, `stable` returns to 1, and no pulse is issued.
- Bounce: `raw_in[CH_SD]` is 1 for 5 cycles, 0 for 2, then held at 1: `clean_out[6]` rises 10 cycles after the final 0→1.
- Simultaneous: `raw_in[CH_M]` and `raw_in[CH_T]` step to 1 in the same cycle: both `clean_out` bits rise in the same cycle, 10 cycles later.
- `Rst` pulsed 4 cycles into a count on `CH_US`, with raw held at 1: outputs clear asynchronously. After release, `clean_out[3]` rises 10 cycles later, not earlier.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor input conditioner: channel indices,
// default sizing and the per-channel debounce state encoding.
package sensor_pkg;

    localparam int CH_H  = 0;
    localparam int CH_M  = 1;
    localparam int CH_L  = 2;
    localparam int CH_US = 3;
    localparam int CH_UA = 4;
    localparam int CH_T  = 5;
    localparam int CH_SD = 6;

    localparam int N_CH_DEF       = 7;
    localparam int DEB_CYCLES_DEF = 50000;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } ch_state_t;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the raw sensor inputs and the conditioned outputs.
// Edge pulse signals exist only when SENSOR_EDGE_EN is defined.
interface sensor_conditioner_if
    import sensor_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
);

    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] clean_out;
    logic            stable;
`ifdef SENSOR_EDGE_EN
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
`endif

`ifdef SENSOR_EDGE_EN
    modport master (output raw_in, input clean_out, input stable, input rise_pulse, input fall_pulse);
    modport slave  (input raw_in, output clean_out, output stable, output rise_pulse, output fall_pulse);
`else
    modport master (output raw_in, input clean_out, input stable);
    modport slave  (input raw_in, output clean_out, output stable);
`endif

endinterface

// File: rtl/debounce_channel.sv
// One conditioned bit: two-flop synchronizer, counter debouncer and, when
// SENSOR_EDGE_EN is defined, registered rise/fall pulses on clean updates.
module debounce_channel
    import sensor_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
    input  logic clock,
    input  logic Rst,
    input  logic i_raw,
    output logic o_clean,
    output logic o_idle
`ifdef SENSOR_EDGE_EN
    ,
    output logic o_rise,
    output logic o_fall
`endif
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_clean;
    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_diff;

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    assign w_diff = r_s2 ^ r_clean;

    // The cycle that leaves IDLE already counts as the first differing cycle,
    // so acceptance lands exactly DEB_CYCLES cycles after s2 changes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_diff) begin
                    w_state_nxt = COUNT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (!w_diff) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == TERM) begin
                    w_accept    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) r_clean <= r_s2;
        end
    end

    assign o_clean = r_clean;
    assign o_idle  = (r_state == IDLE);

`ifdef SENSOR_EDGE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept & r_s2;
            r_fall <= w_accept & ~r_s2;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`endif

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor input conditioner: N_CH independent debounced channels plus a global
// stable flag. Define SENSOR_EDGE_EN to add per-channel rise/fall pulses.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
    input logic                 clock,
    input logic                 Rst,
    sensor_conditioner_if.slave bus
);

    localparam int ST_LIMIT = DEB_CYCLES + 2;
    localparam int ST_W     = $clog2(DEB_CYCLES + 3);

    logic [ST_W-1:0] r_start_cnt;
    logic            r_stable;
    logic            w_start_done;
    logic [N_CH-1:0] w_clean;
    logic [N_CH-1:0] w_idle;
`ifdef SENSOR_EDGE_EN
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
`endif

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        debounce_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clock   (clock),
            .Rst     (Rst),
            .i_raw   (bus.raw_in[gi]),
            .o_clean (w_clean[gi]),
            .o_idle  (w_idle[gi])
`ifdef SENSOR_EDGE_EN
            ,
            .o_rise  (w_rise[gi]),
            .o_fall  (w_fall[gi])
`endif
        );
    end

    assign w_start_done = (r_start_cnt == ST_W'(ST_LIMIT));

    // Startup window saturates; stable is one cycle behind the channel states.
    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            r_start_cnt <= '0;
            r_stable    <= 1'b0;
        end else begin
            if (!w_start_done) r_start_cnt <= r_start_cnt + ST_W'(1);
            r_stable <= w_start_done & (&w_idle);
        end
    end

    assign bus.clean_out = w_clean;
    assign bus.stable    = r_stable;
`ifdef SENSOR_EDGE_EN
    assign bus.rise_pulse = w_rise;
    assign bus.fall_pulse = w_fall;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner with DEB_CYCLES=8; expected
// per-cycle outputs are queued when stimulus is driven and popped each cycle.
module tb_sensor_conditioner;
    import sensor_pkg::*;

    localparam int N   = 7;
    localparam int DEB = 8;

    typedef struct packed {
        logic [N-1:0] clean;
        logic         stb;
        logic         chk_stb;
    } exp_t;

    logic clock = 1'b0;
    logic Rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [N-1:0] prev_clean = '0;

    always #5 clock = ~clock;

    sensor_conditioner_if #(.N_CH(N)) bus ();

    sensor_conditioner #(
        .N_CH       (N),
        .DEB_CYCLES (DEB),
        .CNT_W      ($clog2(DEB))
    ) dut (
        .clock (clock),
        .Rst   (Rst),
        .bus   (bus)
    );

    task automatic test_reset();
        exp_t e;
        Rst = 1'b1;
        bus.raw_in = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.clean_out !== '0 || bus.stable !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold clean=%b stable=%b required clean=0 stable=0", bus.clean_out, bus.stable);
        end
`ifdef SENSOR_EDGE_EN
        checks++;
        if (bus.rise_pulse !== '0 || bus.fall_pulse !== '0) begin
            failures++;
            $display("FAIL reset_pulses rise=%b fall=%b required 0", bus.rise_pulse, bus.fall_pulse);
        end
`endif
        Rst = 1'b0;
        prev_clean = '0;
        for (int k = 1; k <= 13; k++) begin
            e.clean = '0; e.stb = (k >= 11); e.chk_stb = 1'b1;
            sb.push_back(e);
        end
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (bus.clean_out !== e.clean) begin
                failures++;
                $display("FAIL reset_clean k=%0d got=%b exp=%b", k, bus.clean_out, e.clean);
            end
            checks++;
            if (bus.stable !== e.stb) begin
                failures++;
                $display("FAIL reset_stable k=%0d got=%b exp=%b", k, bus.stable, e.stb);
            end
            prev_clean = e.clean;
        end
    endtask

    // Single step on one or more channels; used by the step/glitch/simultaneous scenarios.
    task automatic test_step(input string name, input logic [N-1:0] mask, input int fall_k);
        exp_t e;
        logic [N-1:0] base;
        logic pass;
        base = prev_clean;
        pass = (fall_k == 0);
        bus.raw_in = bus.raw_in | mask;
        for (int k = 1; k <= 14; k++) begin
            e.clean   = (pass && k >= 10) ? (base | mask) : base;
            e.stb     = !(k >= 4 && k <= 10);
            e.chk_stb = 1'b1;
            sb.push_back(e);
        end
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (bus.clean_out !== e.clean) begin
                failures++;
                $display("FAIL %s_clean k=%0d got=%b exp=%b", name, k, bus.clean_out, e.clean);
            end
            checks++;
            if (bus.stable !== e.stb) begin
                failures++;
                $display("FAIL %s_stable k=%0d got=%b exp=%b", name, k, bus.stable, e.stb);
            end
`ifdef SENSOR_EDGE_EN
            checks++;
            if (bus.rise_pulse !== (e.clean & ~prev_clean) || bus.fall_pulse !== (prev_clean & ~e.clean)) begin
                failures++;
                $display("FAIL %s_pulse k=%0d rise=%b fall=%b exp_rise=%b exp_fall=%b", name, k,
                         bus.rise_pulse, bus.fall_pulse, e.clean & ~prev_clean, prev_clean & ~e.clean);
            end
`endif
            prev_clean = e.clean;
            if (k == fall_k) bus.raw_in = bus.raw_in & ~mask;
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        logic [N-1:0] base;
        logic [N-1:0] m;
        base = prev_clean;
        m = '0;
        m[CH_SD] = 1'b1;
        bus.raw_in[CH_SD] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            e.clean   = (k >= 17) ? (base | m) : base;
            e.stb     = 1'b1;
            e.chk_stb = (k >= 19);
            sb.push_back(e);
        end
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (bus.clean_out !== e.clean) begin
                failures++;
                $display("FAIL bounce_clean k=%0d got=%b exp=%b", k, bus.clean_out, e.clean);
            end
            if (e.chk_stb) begin
                checks++;
                if (bus.stable !== e.stb) begin
                    failures++;
                    $display("FAIL bounce_stable k=%0d got=%b exp=%b", k, bus.stable, e.stb);
                end
            end
`ifdef SENSOR_EDGE_EN
            checks++;
            if (bus.rise_pulse !== (e.clean & ~prev_clean) || bus.fall_pulse !== (prev_clean & ~e.clean)) begin
                failures++;
                $display("FAIL bounce_pulse k=%0d rise=%b fall=%b", k, bus.rise_pulse, bus.fall_pulse);
            end
`endif
            prev_clean = e.clean;
            if (k == 5) bus.raw_in[CH_SD] = 1'b0;
            if (k == 7) bus.raw_in[CH_SD] = 1'b1;
        end
    endtask

    task automatic test_rst_mid();
        exp_t e;
        logic [N-1:0] base;
        base = prev_clean;
        bus.raw_in[CH_US] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            e.clean = base; e.stb = (k < 4); e.chk_stb = 1'b1;
            sb.push_back(e);
        end
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (bus.clean_out !== e.clean || bus.stable !== e.stb) begin
                failures++;
                $display("FAIL rstmid_pre k=%0d clean=%b stable=%b exp_clean=%b exp_stable=%b",
                         k, bus.clean_out, bus.stable, e.clean, e.stb);
            end
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (bus.clean_out !== '0 || bus.stable !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async clean=%b stable=%b required clean=0 stable=0", bus.clean_out, bus.stable);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (bus.clean_out !== '0 || bus.stable !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_hold clean=%b stable=%b required clean=0 stable=0", bus.clean_out, bus.stable);
        end
        Rst = 1'b0;
        prev_clean = '0;
        for (int k = 1; k <= 13; k++) begin
            e.clean = (k >= 10) ? bus.raw_in : '0; e.stb = (k >= 11); e.chk_stb = 1'b1;
            sb.push_back(e);
        end
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clock);
            e = sb.pop_front();
            checks++;
            if (bus.clean_out !== e.clean) begin
                failures++;
                $display("FAIL rstmid_clean k=%0d got=%b exp=%b", k, bus.clean_out, e.clean);
            end
            checks++;
            if (bus.stable !== e.stb) begin
                failures++;
                $display("FAIL rstmid_stable k=%0d got=%b exp=%b", k, bus.stable, e.stb);
            end
`ifdef SENSOR_EDGE_EN
            checks++;
            if (bus.rise_pulse !== (e.clean & ~prev_clean)) begin
                failures++;
                $display("FAIL rstmid_rise k=%0d got=%b exp=%b", k, bus.rise_pulse, e.clean & ~prev_clean);
            end
`endif
            prev_clean = e.clean;
        end
    endtask

    initial begin
        logic [N-1:0] m;
        Rst = 1'b1;
        bus.raw_in = '0;
        test_reset();
        m = '0; m[CH_H] = 1'b1;
        test_step("step_h", m, 0);
        m = '0; m[CH_L] = 1'b1;
        test_step("glitch_l", m, 7);
        test_bounce();
        m = '0; m[CH_M] = 1'b1; m[CH_T] = 1'b1;
        test_step("simul_mt", m, 0);
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
